// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: MEM pipeline stage between the EX/MEM and MEM/WB boundaries.
//
// Holds the byte-addressable data memory. It supports byte, half and word accesses
// with sign or zero extension. Loads can be given a configurable extra latency,
// during which upstream is stalled. Misaligned accesses are flagged, and every
// WB-bound field, including the JAL link PC, is registered.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   flush             kill the instruction currently in MEM
//   valid_M .. pc_M   EX/MEM control, address/ALU result, store data, rd, link PC
//   stall_M           upstream must hold its EX/MEM inputs stable
//   alu_result_Mout   combinational copy of alu_result_M for forwarding
//   *_W               registered MEM/WB fields (controls, load data, ALU result, rd,
//                     link PC, misaligned-access flag)
module mem_stage_pipe #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned MEM_LAT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              valid_M,
    input  logic              mem_read_M,
    input  logic              mem_write_M,
    input  logic              mem_to_reg_M,
    input  logic              reg_write_M,
    input  logic              jal_M,
    input  logic [1:0]        size_M,
    input  logic              unsigned_M,
    input  logic [ADDR_W-1:0] alu_result_M,
    input  logic [DATA_W-1:0] write_data_M,
    input  logic [REG_W-1:0]  rd_M,
    input  logic [ADDR_W-1:0] pc_M,
    output logic              stall_M,
    output logic [ADDR_W-1:0] alu_result_Mout,
    output logic              valid_W,
    output logic              mem_to_reg_W,
    output logic              reg_write_W,
    output logic              jal_W,
    output logic [DATA_W-1:0] load_data_W,
    output logic [ADDR_W-1:0] alu_result_W,
    output logic [REG_W-1:0]  rd_W,
    output logic [ADDR_W-1:0] pc_W,
    output logic              misalign_W
);

    localparam int unsigned IdxW    = $clog2(MEM_WORDS);
    // Count value at which the wait ends; the load is captured on the edge after it.
    localparam logic [2:0]  LastCnt = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    // ------------------------------------------------------------------
    // Address decode and access classification
    // ------------------------------------------------------------------
    logic [IdxW-1:0] word_idx;
    logic [1:0]      lane;
    logic            is_byte;
    logic            is_half;
    logic            is_word;
    logic            mis_addr;
    logic            mis;
    logic            do_store;
    logic            do_load;
    logic            lat_load;

    // Upper address bits are ignored, so accesses wrap around the array.
    assign word_idx = alu_result_M[IdxW+1:2];
    assign lane     = alu_result_M[1:0];
    assign is_byte  = (size_M == 2'b00);
    assign is_half  = (size_M == 2'b01);
    assign is_word  = size_M[1];               // 11 (reserved) behaves as word

    assign mis_addr = (is_half & lane[0]) | (is_word & (lane != 2'b00));
    assign mis      = (mem_read_M | mem_write_M) & mis_addr;

    // A simultaneous read and write is treated as a store.
    assign do_store = reset & valid_M & mem_write_M & ~mis & ~flush;
    assign do_load  = valid_M & mem_read_M & ~mem_write_M & ~mis;
    assign lat_load = do_load & ~flush & reset & (MEM_LAT != 0);

    // ------------------------------------------------------------------
    // Load-latency FSM
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       stall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // The entry cycle is the first of the MEM_LAT stall cycles.
                    if (lat_load) begin
                        stall   = 1'b1;
                        state_d = StWait;
                        cnt_d   = 3'd0;
                    end
                end
                StWait: begin
                    if (cnt_q == LastCnt) begin
                        state_d = StIdle;
                        cnt_d   = 3'd0;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset must drop the stall at once, even while a load is still presented.
    assign stall_M         = stall & reset;
    assign alu_result_Mout = alu_result_M;

    // ------------------------------------------------------------------
    // Data memory (not reset)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic [3:0]        be;
    logic [31:0]       wdata_rep;

    // Replicate store data across lanes so each enabled byte picks its own slice.
    always_comb begin
        be        = 4'hF;
        wdata_rep = write_data_M;
        if (is_byte) begin
            be        = 4'b0001 << lane;
            wdata_rep = {4{write_data_M[7:0]}};
        end else if (is_half) begin
            be        = 4'b0011 << lane;
            wdata_rep = {2{write_data_M[15:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: asynchronous read, lane extract, extend
    // ------------------------------------------------------------------
    logic [31:0] rdata;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    assign rdata   = mem_q[word_idx];
    assign shifted = rdata >> {lane, 3'b000};

    always_comb begin
        if (is_byte) begin
            load_ext = {{24{~unsigned_M & shifted[7]}}, shifted[7:0]};
        end else if (is_half) begin
            load_ext = {{16{~unsigned_M & shifted[15]}}, shifted[15:0]};
        end else begin
            load_ext = shifted;                // word accesses are aligned, lane 0
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB register
    // ------------------------------------------------------------------
    logic              bubble;
    logic              valid_q, mem_to_reg_q, reg_write_q, jal_q, misalign_q;
    logic [DATA_W-1:0] load_data_q;
    logic [ADDR_W-1:0] alu_result_q, pc_q;
    logic [REG_W-1:0]  rd_q;

    // stall_M already excludes flush, so flush and stall both land here as a bubble.
    assign bubble = ~valid_M | flush | stall_M;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            jal_q        <= 1'b0;
            misalign_q   <= 1'b0;
            load_data_q  <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
            pc_q         <= '0;
        end else if (bubble) begin
            valid_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            jal_q        <= 1'b0;
            misalign_q   <= 1'b0;
            load_data_q  <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
            pc_q         <= '0;
        end else begin
            valid_q      <= 1'b1;
            mem_to_reg_q <= mem_to_reg_M;
            reg_write_q  <= reg_write_M & ~mis;
            jal_q        <= jal_M;
            misalign_q   <= mis;
            load_data_q  <= do_load ? load_ext : '0;
            alu_result_q <= alu_result_M;
            rd_q         <= rd_M;
            pc_q         <= pc_M;
        end
    end

    assign valid_W      = valid_q;
    assign mem_to_reg_W = mem_to_reg_q;
    assign reg_write_W  = reg_write_q;
    assign jal_W        = jal_q;
    assign misalign_W   = misalign_q;
    assign load_data_W  = load_data_q;
    assign alu_result_W = alu_result_q;
    assign rd_W         = rd_q;
    assign pc_W         = pc_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Testbench for mem_stage_pipe (MEM_LAT=3, MEM_WORDS=256). A byte-array model of
// the stage predicts every WB field and the stall output each cycle; directed
// vectors add hand-computed literal expectations.
module tb_mem_stage_pipe;

    localparam int unsigned LAT   = 3;
    localparam int unsigned WORDS = 256;
    localparam int unsigned BYTES = WORDS * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        valid_M, mem_read_M, mem_write_M, mem_to_reg_M, reg_write_M, jal_M;
    logic [1:0]  size_M;
    logic        unsigned_M;
    logic [31:0] alu_result_M, write_data_M, pc_M;
    logic [4:0]  rd_M;
    logic        stall_M;
    logic [31:0] alu_result_Mout;
    logic        valid_W, mem_to_reg_W, reg_write_W, jal_W, misalign_W;
    logic [31:0] load_data_W, alu_result_W, pc_W;
    logic [4:0]  rd_W;

    always #5 clk = ~clk;

    mem_stage_pipe #(
        .DATA_W(32), .ADDR_W(32), .REG_W(5), .MEM_WORDS(WORDS), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .valid_M(valid_M),
        .mem_read_M(mem_read_M), .mem_write_M(mem_write_M), .mem_to_reg_M(mem_to_reg_M),
        .reg_write_M(reg_write_M), .jal_M(jal_M), .size_M(size_M), .unsigned_M(unsigned_M),
        .alu_result_M(alu_result_M), .write_data_M(write_data_M), .rd_M(rd_M), .pc_M(pc_M),
        .stall_M(stall_M), .alu_result_Mout(alu_result_Mout), .valid_W(valid_W),
        .mem_to_reg_W(mem_to_reg_W), .reg_write_W(reg_write_W), .jal_W(jal_W),
        .load_data_W(load_data_W), .alu_result_W(alu_result_W), .rd_W(rd_W), .pc_W(pc_W),
        .misalign_W(misalign_W)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model state: byte-wide memory, expected WB fields, cycles the current load has stalled.
    logic [7:0]  mem_m [BYTES];
    logic        e_valid, e_m2r, e_rw, e_jal, e_mis;
    logic [31:0] e_ld, e_alu, e_pc;
    logic [4:0]  e_rd;
    int          occ;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        e_valid = 0; e_m2r = 0; e_rw = 0; e_jal = 0; e_mis = 0;
        e_ld = 0; e_alu = 0; e_pc = 0; e_rd = 0;
    endtask

    function automatic int nbytes();
        return (size_M == 2'b00) ? 1 : (size_M == 2'b01) ? 2 : 4;
    endfunction

    // An access is misaligned when its address is not a multiple of its size.
    function automatic logic model_mis();
        return (mem_read_M || mem_write_M) && ((alu_result_M % nbytes()) != 0);
    endfunction

    // A good load occupies MEM for LAT+1 cycles and stalls for the first LAT of them.
    function automatic logic model_stall();
        return reset && valid_M && mem_read_M && !mem_write_M && !model_mis() && !flush
               && (occ < LAT);
    endfunction

    task automatic model_update();
        logic        s;
        logic        m;
        int          nb;
        logic [31:0] base;
        logic [31:0] v;
        s    = model_stall();
        m    = model_mis();
        nb   = nbytes();
        base = alu_result_M % BYTES;
        if (!valid_M || flush || s) begin
            model_clear();
            occ = s ? occ + 1 : 0;
        end else begin
            e_valid = 1; e_m2r = mem_to_reg_M; e_rw = reg_write_M && !m; e_jal = jal_M;
            e_mis = m; e_alu = alu_result_M; e_rd = rd_M; e_pc = pc_M; e_ld = 0;
            if (mem_write_M && !m) begin
                for (int i = 0; i < nb; i++) mem_m[(base + i) % BYTES] = write_data_M[8*i +: 8];
            end else if (mem_read_M && !m) begin
                v = 0;
                for (int i = 0; i < nb; i++) v = v | (32'(mem_m[(base + i) % BYTES]) << (8 * i));
                if (!unsigned_M && nb == 1 && v[7])  v = v | 32'hFFFFFF00;
                if (!unsigned_M && nb == 2 && v[15]) v = v | 32'hFFFF0000;
                e_ld = v;
            end
            occ = 0;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("stall_M", 32'(stall_M), 32'(model_stall()));
            check("alu_result_Mout", alu_result_Mout, alu_result_M);
            check("valid_W", 32'(valid_W), 32'(e_valid));
            check("mem_to_reg_W", 32'(mem_to_reg_W), 32'(e_m2r));
            check("reg_write_W", 32'(reg_write_W), 32'(e_rw));
            check("jal_W", 32'(jal_W), 32'(e_jal));
            check("misalign_W", 32'(misalign_W), 32'(e_mis));
            check("load_data_W", load_data_W, e_ld);
            check("alu_result_W", alu_result_W, e_alu);
            check("rd_W", 32'(rd_W), 32'(e_rd));
            check("pc_W", pc_W, e_pc);
        end
    end

    task automatic step();
        @(posedge clk);
        model_update();
        #2;
    endtask

    task automatic set_in(input logic v, input logic rd, input logic wr, input logic m2r,
                          input logic rw, input logic j, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input logic [4:0] r,
                          input logic [31:0] p);
        valid_M = v; mem_read_M = rd; mem_write_M = wr; mem_to_reg_M = m2r;
        reg_write_M = rw; jal_M = j; size_M = sz; unsigned_M = u;
        alu_result_M = a; write_data_M = wd; rd_M = r; pc_M = p;
    endtask

    task automatic nop();
        set_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 32'h0);
        step();
    endtask

    task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        set_in(1, 0, 1, 0, 0, 0, sz, 0, a, wd, 5'd0, 32'h0);
        step();
    endtask

    // Holds the load until the model says it leaves MEM; counts stall cycles and bubbles.
    task automatic load(input logic [1:0] sz, input logic u, input logic [31:0] a,
                        output int stalls, output int bubbles);
        logic s;
        bit   done;
        set_in(1, 1, 0, 1, 1, 0, sz, u, a, 32'h0, 5'd3, 32'h0);
        stalls = 0; bubbles = 0; done = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            if (stall_M) stalls++;
            s = model_stall();
            step();
            if (s && !valid_W) bubbles++;
            if (!s) begin
                done = 1;
                break;
            end
        end
        if (!done) check("load_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        int st, bu;
        flush = 0;
        set_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 32'h0);
        reset = 0;
        occ   = 0;
        model_clear();
        @(posedge clk);
        #2;
        check("rst_stall", 32'(stall_M), 32'd0);
        check("rst_valid_W", 32'(valid_W), 32'd0);
        check("rst_pc_W", pc_W, 32'd0);
        reset  = 1;
        chk_en = 1;

        // Byte store into lane 3, then byte loads and a word readback.
        store(2'b10, 32'h00, 32'h11223344);
        store(2'b00, 32'h03, 32'h000000A5);
        load(2'b00, 1, 32'h03, st, bu);
        check("lbu_a5", load_data_W, 32'h000000A5);
        check("model_lbu", e_ld, 32'h000000A5);
        load(2'b00, 0, 32'h03, st, bu);
        check("lb_a5", load_data_W, 32'hFFFFFFA5);
        load(2'b10, 0, 32'h00, st, bu);
        check("lw_after_sb", load_data_W, 32'hA5223344);

        // Half store and signed/unsigned half loads.
        store(2'b01, 32'h02, 32'h12348001);
        load(2'b01, 0, 32'h02, st, bu);
        check("lh_8001", load_data_W, 32'hFFFF8001);
        check("model_lh", e_ld, 32'hFFFF8001);
        load(2'b01, 1, 32'h02, st, bu);
        check("lhu_8001", load_data_W, 32'h00008001);

        // Misaligned load and store.
        store(2'b10, 32'h04, 32'hCAFEF00D);
        load(2'b10, 0, 32'h06, st, bu);
        check("mis_stalls", 32'(st), 32'd0);
        check("mis_flag", 32'(misalign_W), 32'd1);
        check("mis_rw", 32'(reg_write_W), 32'd0);
        check("mis_data", load_data_W, 32'd0);
        store(2'b10, 32'h05, 32'h00000000);
        check("mis_st_flag", 32'(misalign_W), 32'd1);
        load(2'b10, 0, 32'h04, st, bu);
        check("mis_st_nowrite", load_data_W, 32'hCAFEF00D);

        // Latency: three stall cycles and three bubbles, then the load lands.
        store(2'b10, 32'h10, 32'h12345678);
        load(2'b10, 0, 32'h10, st, bu);
        check("lat_stalls", 32'(st), 32'd3);
        check("lat_bubbles", 32'(bu), 32'd3);
        check("lat_valid", 32'(valid_W), 32'd1);
        check("lat_data", load_data_W, 32'h12345678);

        // Flush on the second stall cycle.
        set_in(1, 1, 0, 1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd7, 32'h0);
        step();
        flush = 1;
        #1;
        check("flush_stall", 32'(stall_M), 32'd0);
        step();
        check("flush_valid", 32'(valid_W), 32'd0);
        check("flush_rw", 32'(reg_write_W), 32'd0);
        flush = 0;
        nop();

        // Flushed store leaves memory alone.
        set_in(1, 0, 1, 0, 0, 0, 2'b10, 0, 32'h10, 32'hFFFFFFFF, 5'd0, 32'h0);
        flush = 1;
        step();
        flush = 0;
        load(2'b10, 0, 32'h10, st, bu);
        check("flush_st_nowrite", load_data_W, 32'h12345678);

        // Address wrap-around.
        store(2'b10, 32'h400, 32'hDEADBEEF);
        load(2'b10, 0, 32'h000, st, bu);
        check("wrap_data", load_data_W, 32'hDEADBEEF);
        check("model_wrap", e_ld, 32'hDEADBEEF);

        // JAL passes through in one cycle.
        set_in(1, 0, 0, 0, 1, 1, 2'b10, 0, 32'h48, 32'h0, 5'd1, 32'h44);
        step();
        check("jal_W", 32'(jal_W), 32'd1);
        check("jal_pc", pc_W, 32'h44);
        check("jal_alu", alu_result_W, 32'h48);
        check("jal_rd", 32'(rd_W), 32'd1);

        // Read and write together act as a store, no stall.
        set_in(1, 1, 1, 1, 1, 0, 2'b10, 0, 32'h20, 32'h55AA55AA, 5'd2, 32'h0);
        #1;
        check("rw_stall", 32'(stall_M), 32'd0);
        step();
        check("rw_ld", load_data_W, 32'd0);
        load(2'b10, 0, 32'h20, st, bu);
        check("rw_written", load_data_W, 32'h55AA55AA);

        // Reset while waiting: outputs clear before any edge.
        set_in(1, 1, 0, 1, 1, 0, 2'b10, 0, 32'h10, 32'h0, 5'd9, 32'h0);
        step();
        step();
        chk_en = 0;
        reset  = 0;
        #1;
        check("rstw_stall", 32'(stall_M), 32'd0);
        check("rstw_valid", 32'(valid_W), 32'd0);
        check("rstw_ld", load_data_W, 32'd0);
        check("rstw_alu", alu_result_W, 32'd0);
        model_clear();
        occ = 0;
        set_in(0, 0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 32'h0);
        @(posedge clk);
        #2;
        reset  = 1;
        chk_en = 1;
        load(2'b10, 0, 32'h10, st, bu);
        check("post_rst_stalls", 32'(st), 32'd3);
        check("post_rst_data", load_data_W, 32'h12345678);
        nop();
        nop();

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
